// File: rtl/wave_pkg.sv
// Shared types and constants for the sawtooth generator / monitor pair.
package wave_pkg;

  // Monitor lock state machine
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Default sample width shared with the wave generator
  localparam int SAMPLE_W = 8;

  // Saturating 8-bit increment used by the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sawtooth_wave_monitor_if.sv
// Sample stream in, lock/period/error status out.
interface sawtooth_wave_monitor_if
  import wave_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PERIOD_W = 16
);
  logic                clear;
  logic                sample_valid;
  logic [WIDTH-1:0]    sample_in;
  logic                locked;
  logic                wrap_pulse;
  logic                period_valid;
  logic [PERIOD_W-1:0] period;
  logic [WIDTH-1:0]    peak;
  logic                err_step;
  logic [7:0]          err_count;

  // Stream source / status consumer side
  modport master (
    output clear, sample_valid, sample_in,
    input  locked, wrap_pulse, period_valid, period, peak, err_step, err_count
  );

  // Monitor side
  modport slave (
    input  clear, sample_valid, sample_in,
    output locked, wrap_pulse, period_valid, period, peak, err_step, err_count
  );
endinterface

// File: rtl/sawtooth_step_check.sv
// Combinational ramp step classifier: good = exact +STEP (mod 2^WIDTH),
// wrap = good step that rolled over.
module sawtooth_step_check #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] sample_in,
  output logic             good,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] expected;

  // Modulo arithmetic falls out of the fixed-width add
  always_comb begin
    expected = prev + STEP_W;
    good     = (sample_in == expected);
    wrap     = good && (sample_in < prev);
  end
endmodule

// File: rtl/sawtooth_wave_monitor.sv
// Sawtooth stream checker: acquires lock on a clean +STEP ramp, measures
// period/peak between wraps while locked, and flags broken steps.
module sawtooth_wave_monitor
  import wave_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sawtooth_wave_monitor_if.slave  mon
);
  localparam logic [3:0]          LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

  state_t              state;
  logic [WIDTH-1:0]    prev;
  logic [WIDTH-1:0]    seg_max;
  logic [3:0]          good_cnt;
  logic [PERIOD_W-1:0] period_cnt;
  logic                ref_ok;

  logic                locked_q;
  logic                wrap_q;
  logic                pvalid_q;
  logic [PERIOD_W-1:0] period_q;
  logic [WIDTH-1:0]    peak_q;
  logic                err_q;
  logic [7:0]          err_cnt_q;

  logic good;
  logic wrap;

  sawtooth_step_check #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .prev      (prev),
    .sample_in (mon.sample_in),
    .good      (good),
    .wrap      (wrap)
  );

  // Lock FSM, period/peak measurement and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev       <= '0;
      seg_max    <= '0;
      good_cnt   <= '0;
      period_cnt <= '0;
      ref_ok     <= 1'b0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      pvalid_q   <= 1'b0;
      period_q   <= '0;
      peak_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wrap_q   <= 1'b0;
      pvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (mon.clear) begin
        // clear wins over a coincident sample; measurements are kept
        state     <= IDLE;
        good_cnt  <= '0;
        ref_ok    <= 1'b0;
        err_cnt_q <= '0;
        locked_q  <= 1'b0;
      end else if (mon.sample_valid) begin
        prev <= mon.sample_in;
        case (state)
          IDLE: begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
          ACQUIRE: begin
            if (good) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              // a bad step that looks like a rollover is still an error
              err_q     <= 1'b1;
              err_cnt_q <= sat_inc8(err_cnt_q);
              state     <= ACQUIRE;
              good_cnt  <= '0;
              ref_ok    <= 1'b0;
              locked_q  <= 1'b0;
            end else if (wrap) begin
              wrap_q <= 1'b1;
              // first wrap after lock only establishes the reference point
              if (ref_ok) begin
                period_q <= period_cnt;
                peak_q   <= seg_max;
                pvalid_q <= 1'b1;
              end
              period_cnt <= PERIOD_W'(1);
              seg_max    <= mon.sample_in;
              ref_ok     <= 1'b1;
            end else begin
              if (period_cnt != PCNT_MAX) period_cnt <= period_cnt + 1'b1;
              if (mon.sample_in > seg_max) seg_max <= mon.sample_in;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.locked       = locked_q;
  assign mon.wrap_pulse   = wrap_q;
  assign mon.period_valid = pvalid_q;
  assign mon.period       = period_q;
  assign mon.peak         = peak_q;
  assign mon.err_step     = err_q;
  assign mon.err_count    = err_cnt_q;

endmodule

// File: tb/tb_sawtooth_wave_monitor.sv
// Directed bench: STEP=1 monitor for lock/ramp/error/gap/clear/reset,
// plus a STEP=3 monitor for modulo wrap handling.
module tb_sawtooth_wave_monitor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sawtooth_wave_monitor_if #(.WIDTH(8), .PERIOD_W(16)) bus1 ();
  sawtooth_wave_monitor_if #(.WIDTH(8), .PERIOD_W(16)) bus3 ();

  sawtooth_wave_monitor #(.WIDTH(8), .STEP(1), .LOCK_COUNT(4), .PERIOD_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .mon(bus1.slave)
  );
  sawtooth_wave_monitor #(.WIDTH(8), .STEP(3), .LOCK_COUNT(4), .PERIOD_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .mon(bus3.slave)
  );

  task automatic tick1(input logic v, input logic [7:0] d);
    bus1.sample_valid = v;
    bus1.sample_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic tick3(input logic v, input logic [7:0] d);
    bus3.sample_valid = v;
    bus3.sample_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus1.locked, bus1.wrap_pulse, bus1.period_valid, bus1.err_step} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000",
        {bus1.locked, bus1.wrap_pulse, bus1.period_valid, bus1.err_step});
    end
    checks++;
    if (bus1.period !== 16'd0 || bus1.peak !== 8'd0 || bus1.err_count !== 8'd0) begin
      errors++; $display("FAIL reset_values got period=%0d peak=%0d errc=%0d want 0",
        bus1.period, bus1.peak, bus1.err_count);
    end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_lock();
    for (int v = 0; v <= 3; v++) begin
      tick1(1'b1, 8'(v));
      checks++;
      if (bus1.locked !== 1'b0) begin
        errors++; $display("FAIL lock_early sample=%0d got %b want 0", v, bus1.locked);
      end
    end
    tick1(1'b1, 8'd4);
    checks++;
    if (bus1.locked !== 1'b1) begin
      errors++; $display("FAIL lock_rise got %b want 1", bus1.locked);
    end
    checks++;
    if (bus1.err_count !== 8'd0) begin
      errors++; $display("FAIL lock_errc got %0d want 0", bus1.err_count);
    end
  endtask

  task automatic test_ramp();
    for (int v = 5; v <= 255; v++) tick1(1'b1, 8'(v));
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v <= 255; v++) begin
        tick1(1'b1, 8'(v));
        checks++;
        if (bus1.wrap_pulse !== (v == 0)) begin
          errors++; $display("FAIL ramp_wrap r=%0d v=%0d got %b", r, v, bus1.wrap_pulse);
        end
        checks++;
        if (bus1.period_valid !== (v == 0 && r > 0)) begin
          errors++; $display("FAIL ramp_pvalid r=%0d v=%0d got %b", r, v, bus1.period_valid);
        end
        if (v == 0 && r > 0) begin
          checks++;
          if (bus1.period !== 16'd256 || bus1.peak !== 8'd255) begin
            errors++; $display("FAIL ramp_meas r=%0d got period=%0d peak=%0d want 256/255",
              r, bus1.period, bus1.peak);
          end
        end
      end
    end
    checks++;
    if (bus1.locked !== 1'b1 || bus1.err_count !== 8'd0) begin
      errors++; $display("FAIL ramp_state got locked=%b errc=%0d want 1/0", bus1.locked, bus1.err_count);
    end
  endtask

  task automatic test_error();
    for (int v = 0; v <= 11; v++) tick1(1'b1, 8'(v));
    tick1(1'b1, 8'd13);
    checks++;
    if (bus1.err_step !== 1'b1 || bus1.err_count !== 8'd1 || bus1.locked !== 1'b0) begin
      errors++; $display("FAIL err_hit got err=%b errc=%0d locked=%b want 1/1/0",
        bus1.err_step, bus1.err_count, bus1.locked);
    end
    for (int v = 14; v <= 16; v++) begin
      tick1(1'b1, 8'(v));
      checks++;
      if (bus1.locked !== 1'b0 || bus1.err_step !== 1'b0) begin
        errors++; $display("FAIL err_relock_early v=%0d got locked=%b err=%b want 0/0",
          v, bus1.locked, bus1.err_step);
      end
    end
    tick1(1'b1, 8'd17);
    checks++;
    if (bus1.locked !== 1'b1) begin
      errors++; $display("FAIL err_relock got %b want 1", bus1.locked);
    end
    for (int v = 18; v <= 255; v++) tick1(1'b1, 8'(v));
    tick1(1'b1, 8'd0);
    checks++;
    if (bus1.wrap_pulse !== 1'b1 || bus1.period_valid !== 1'b0) begin
      errors++; $display("FAIL err_refwrap got wrap=%b pv=%b want 1/0", bus1.wrap_pulse, bus1.period_valid);
    end
    for (int v = 1; v <= 255; v++) tick1(1'b1, 8'(v));
    tick1(1'b1, 8'd0);
    checks++;
    if (bus1.period_valid !== 1'b1 || bus1.period !== 16'd256 || bus1.peak !== 8'd255) begin
      errors++; $display("FAIL err_meas got pv=%b period=%0d peak=%0d want 1/256/255",
        bus1.period_valid, bus1.period, bus1.peak);
    end
    checks++;
    if (bus1.err_count !== 8'd1) begin
      errors++; $display("FAIL err_count_hold got %0d want 1", bus1.err_count);
    end
  endtask

  task automatic test_gaps();
    for (int v = 1; v <= 255; v++) begin
      tick1(1'b1, 8'(v));
      tick1(1'b0, 8'hAA);
      checks++;
      if ({bus1.wrap_pulse, bus1.period_valid, bus1.err_step} !== 3'b000) begin
        errors++; $display("FAIL gap_pulse v=%0d got %b want 000",
          v, {bus1.wrap_pulse, bus1.period_valid, bus1.err_step});
      end
    end
    tick1(1'b1, 8'd0);
    checks++;
    if (bus1.period_valid !== 1'b1 || bus1.period !== 16'd256 || bus1.peak !== 8'd255) begin
      errors++; $display("FAIL gap_meas got pv=%b period=%0d peak=%0d want 1/256/255",
        bus1.period_valid, bus1.period, bus1.peak);
    end
  endtask

  task automatic test_step3();
    bus1.sample_valid = 1'b0;
    for (int v = 238; v <= 250; v += 3) tick3(1'b1, 8'(v));
    checks++;
    if (bus3.locked !== 1'b1) begin
      errors++; $display("FAIL s3_lock got %b want 1", bus3.locked);
    end
    tick3(1'b1, 8'd253);
    tick3(1'b1, 8'd0);
    checks++;
    if (bus3.wrap_pulse !== 1'b1 || bus3.err_step !== 1'b0) begin
      errors++; $display("FAIL s3_wrap got wrap=%b err=%b want 1/0", bus3.wrap_pulse, bus3.err_step);
    end
    bus3.clear = 1'b1;
    tick3(1'b0, 8'd0);
    bus3.clear = 1'b0;
    for (int v = 238; v <= 253; v += 3) tick3(1'b1, 8'(v));
    tick3(1'b1, 8'd1);
    checks++;
    if (bus3.err_step !== 1'b1 || bus3.wrap_pulse !== 1'b0 || bus3.err_count !== 8'd1) begin
      errors++; $display("FAIL s3_err got err=%b wrap=%b errc=%0d want 1/0/1",
        bus3.err_step, bus3.wrap_pulse, bus3.err_count);
    end
    bus3.sample_valid = 1'b0;
  endtask

  task automatic test_clear_reset();
    bus1.clear = 1'b1;
    tick1(1'b1, 8'd77);
    bus1.clear = 1'b0;
    checks++;
    if (bus1.err_step !== 1'b0 || bus1.locked !== 1'b0 || bus1.err_count !== 8'd0) begin
      errors++; $display("FAIL clr_flags got err=%b locked=%b errc=%0d want 0/0/0",
        bus1.err_step, bus1.locked, bus1.err_count);
    end
    checks++;
    if (bus1.period !== 16'd256 || bus1.peak !== 8'd255) begin
      errors++; $display("FAIL clr_hold got period=%0d peak=%0d want 256/255", bus1.period, bus1.peak);
    end
    for (int v = 5; v <= 8; v++) tick1(1'b1, 8'(v));
    checks++;
    if (bus1.locked !== 1'b0) begin
      errors++; $display("FAIL clr_idle got locked=%b want 0", bus1.locked);
    end
    tick1(1'b1, 8'd9);
    checks++;
    if (bus1.locked !== 1'b1) begin
      errors++; $display("FAIL clr_relock got %b want 1", bus1.locked);
    end
    tick1(1'b1, 8'd10);
    tick1(1'b1, 8'd11);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus1.locked !== 1'b0 || bus1.period !== 16'd0 || bus1.peak !== 8'd0 ||
        bus1.err_count !== 8'd0 || bus3.err_count !== 8'd0) begin
      errors++; $display("FAIL async_reset got locked=%b period=%0d peak=%0d errc=%0d errc3=%0d want 0",
        bus1.locked, bus1.period, bus1.peak, bus1.err_count, bus3.err_count);
    end
    bus1.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus1.clear = 1'b0; bus1.sample_valid = 1'b0; bus1.sample_in = '0;
    bus3.clear = 1'b0; bus3.sample_valid = 1'b0; bus3.sample_in = '0;
    test_reset();
    test_lock();
    test_ramp();
    test_error();
    test_gaps();
    test_step3();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sawtooth_wave_monitor.md
Name: sawtooth_wave_monitor

Overview:
Consumer-side checker for the 8-bit sawtooth sample stream produced by the wave generator. It tracks consecutive samples, verifies the +STEP ramp, detects wrap-around, measures period and peak per ramp, and reports lock and step errors. It sits downstream of the generator, or of any DAC-feedback path that carries the same stream, in self-test and bring-up builds.

Parameters:
WIDTH, 8, sample width in bits
STEP, 1, expected increment per valid sample (modulo 2^WIDTH)
LOCK_COUNT, 4, number of consecutive good steps required to enter LOCKED (range 1..15)
PERIOD_W, 16, width of the period counter and output

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear: returns to IDLE, zeroes err_count
sample_valid  in  1  sample_in is valid this cycle
sample_in  in  WIDTH  sawtooth sample
locked  out  1  level; high while in LOCKED
wrap_pulse  out  1  one-cycle pulse on a detected wrap
period_valid  out  1  one-cycle pulse; period holds a new measurement
period  out  PERIOD_W  valid samples from one wrap sample up to (excluding) the next
peak  out  WIDTH  largest sample of the last completed ramp
err_step  out  1  one-cycle pulse on a bad step while LOCKED
err_count  out  8  saturating count of err_step events

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE. All outputs 0. prev, good_cnt, period_cnt and ref_ok are cleared.
- All outputs are registered. The response to a valid sample appears on the cycle after the clock edge that samples it (latency 1). Cycles with sample_valid=0 change nothing and all pulses are 0.
- expected = (prev + STEP) mod 2^WIDTH. A step is good when sample_in == expected.
- A wrap is a good step with sample_in < prev.
- FSM states:
  - IDLE: first valid sample: prev <= sample_in, go to ACQUIRE, good_cnt=0.
  - ACQUIRE: good step increments good_cnt. When good_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 that cycle. Bad step sets good_cnt=0 and does not flag an error.
  - LOCKED:
    - good step: stay in LOCKED.
    - bad step: err_step=1, err_count+1 (saturates at 255), go to ACQUIRE, good_cnt=0, ref_ok=0, locked=0.
- prev <= sample_in on every valid sample, in every state.
- Period and peak, LOCKED state only:
  - Each valid sample increments period_cnt, saturating at 2^PERIOD_W-1, and updates seg_max.
  - On a wrap: wrap_pulse=1. If ref_ok=1, then period <= period_cnt, peak <= seg_max and period_valid=1. In all cases, then period_cnt <= 1, seg_max <= sample_in and ref_ok <= 1.
  - The first wrap after lock only sets the reference and produces no period_valid.
  - Wraps seen in ACQUIRE are not reported.
- A bad step that also satisfies sample_in < prev is an error, not a wrap.
- clear=1 takes priority over sample_valid: the sample is discarded, state goes to IDLE, and err_count, good_cnt and ref_ok are zeroed. period and peak hold their values; locked drops to 0.
- Reset asserted mid-ramp aborts immediately. No outputs are retained.
- Nominal WIDTH=8, STEP=1 stream: period=256, peak=255.

Decomposition:
- Shared package (wave_pkg): the FSM state enum (IDLE, ACQUIRE, LOCKED) and a default sample-width constant of 8, also used by the generator.
- One natural sub-module: sawtooth_step_check. It is combinational; it takes prev, sample_in and STEP and returns good and wrap.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset, then feed samples 0,1,2,3,4 with valid=1 each cycle -> locked rises 1 cycle after sample 4 is sampled (LOCK_COUNT=4); err_count=0.
- Continuous 0..255 ramp for 3 full cycles -> wrap_pulse at each 255->0; first period_valid on the second wrap with period=256, peak=255; same values on the third wrap.
- While locked, inject 10,11,13 -> err_step pulse 1 cycle after 13 is sampled, err_count=1, locked=0; after 4 further good steps locked=1 again; next period_valid only after two more wraps.
- Gaps: toggle sample_valid 1/0 over a 0..255 ramp -> period still 256; no pulses on invalid cycles.
- STEP=3 build, ramp 250,253,0 (256 mod) -> wrap detected at 0 with no error; 250,253,1 -> err_step.
- clear asserted together with a valid bad sample -> no err_step; state IDLE, err_count=0, period and peak unchanged; reset_n pulled low mid-ramp -> all outputs 0 asynchronously.
